// File: rtl/hm10_at_sequencer_pkg.sv
// Shared types and constants for the HM-10 AT command sequencer.
package hm10_cfg_pkg;
    typedef enum logic [2:0] {IDLE, SEND, WAIT_RSP, GAP, DONE, FAIL} state_t;

    localparam logic [7:0] ASCII_O = 8'h4F;
    localparam logic [7:0] ASCII_K = 8'h4B;

    localparam int NUM_CMDS = 3;
    localparam int CMD_W    = 2;
    localparam int CHAR_W   = 4;

    localparam int CMD0_LEN = 2;   // "AT"
    localparam int CMD1_LEN = 11;  // "AT+NAMEFPGA"
    localparam int CMD2_LEN = 8;   // "AT+ROLE0"

    // Index of the final byte of a command.
    function automatic logic [CHAR_W-1:0] last_char(input logic [CMD_W-1:0] idx);
        case (idx)
            2'd0:    return CHAR_W'(CMD0_LEN - 1);
            2'd1:    return CHAR_W'(CMD1_LEN - 1);
            2'd2:    return CHAR_W'(CMD2_LEN - 1);
            default: return '0;
        endcase
    endfunction
endpackage

// File: rtl/hm10_at_sequencer_if.sv
// Byte handshake towards the UART transmitter and strobe from the receiver.
interface hm10_at_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid);
    modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/hm10_cmd_rom.sv
// Fixed AT command strings; maps (command, character) to a byte and a last flag.
module hm10_cmd_rom
    import hm10_cfg_pkg::*;
(
    input  logic [CMD_W-1:0]  cmd_idx,
    input  logic [CHAR_W-1:0] char_idx,
    output logic [7:0]        data,
    output logic              last
);
    // Index 0 is the first character on the wire.
    localparam logic [0:CMD0_LEN-1][7:0] CMD0 = "AT";
    localparam logic [0:CMD1_LEN-1][7:0] CMD1 = "AT+NAMEFPGA";
    localparam logic [0:CMD2_LEN-1][7:0] CMD2 = "AT+ROLE0";

    // Byte lookup; out-of-range characters read as zero.
    always_comb begin
        data = '0;
        case (cmd_idx)
            2'd0: if (char_idx < CHAR_W'(CMD0_LEN)) data = CMD0[char_idx[0]];
            2'd1: if (char_idx < CHAR_W'(CMD1_LEN)) data = CMD1[char_idx];
            2'd2: if (char_idx < CHAR_W'(CMD2_LEN)) data = CMD2[char_idx[2:0]];
            default: data = '0;
        endcase
    end

    assign last = (char_idx == last_char(cmd_idx));
endmodule

// File: rtl/hm10_at_sequencer.sv
// Sends the AT command list to an HM-10, waits for "OK" after each, retries on timeout.
module hm10_at_sequencer
    import hm10_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYC = 25000000,
    parameter int GAP_CYC     = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    hm10_at_sequencer_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [CMD_W-1:0]   cmd_idx
);
    localparam int TIMER_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
    // The retry count must be able to hold MAX_RETRY itself.
    localparam int RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t               state, state_nxt;
    logic [CMD_W-1:0]     cmd_nxt;
    logic [CHAR_W-1:0]    chr, chr_nxt;
    logic [RETRY_W-1:0]   retry, retry_nxt;
    logic [TIMER_W-1:0]   timer, timer_nxt;
    logic                 m1, m1_nxt;
    logic                 ok, ok_nxt;
    logic                 matched;
    logic                 tx_valid_q, tx_valid_nxt;
    logic [7:0]           tx_data_q;
    logic                 last_q;
    logic                 busy_nxt, done_nxt, error_nxt;
    logic [7:0]           rom_data;
    logic                 rom_last;

    // ROM is addressed with the next position so tx_data and the last flag are registered.
    hm10_cmd_rom rom (
        .cmd_idx  (cmd_nxt),
        .char_idx (chr_nxt),
        .data     (rom_data),
        .last     (rom_last)
    );

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        cmd_nxt      = cmd_idx;
        chr_nxt      = chr;
        retry_nxt    = retry;
        timer_nxt    = timer;
        m1_nxt       = m1;
        ok_nxt       = ok;
        matched      = 1'b0;
        tx_valid_nxt = tx_valid_q;
        busy_nxt     = busy;
        done_nxt     = done;
        error_nxt    = error;
        case (state)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    state_nxt    = SEND;
                    cmd_nxt      = '0;
                    chr_nxt      = '0;
                    retry_nxt    = '0;
                    done_nxt     = 1'b0;
                    error_nxt    = 1'b0;
                    busy_nxt     = 1'b1;
                    tx_valid_nxt = 1'b1;
                end
            end
            SEND: begin
                if (tx_valid_q && bus.tx_ready) begin
                    if (last_q) begin
                        state_nxt    = WAIT_RSP;
                        timer_nxt    = '0;
                        m1_nxt       = 1'b0;
                        tx_valid_nxt = 1'b0;
                    end else begin
                        chr_nxt = chr + CHAR_W'(1);
                    end
                end
            end
            WAIT_RSP: begin
                timer_nxt = timer + TIMER_W'(1);
                // 'O' always (re)arms the matcher, so "OOK" still matches.
                if (bus.rx_valid) begin
                    matched = m1 && (bus.rx_data == ASCII_K);
                    m1_nxt  = (bus.rx_data == ASCII_O);
                end
                if (matched) begin
                    state_nxt = GAP;
                    timer_nxt = '0;
                    ok_nxt    = 1'b1;
                end else if (timer == TIMER_W'(TIMEOUT_CYC - 1)) begin
                    if (retry < RETRY_W'(MAX_RETRY)) begin
                        retry_nxt = retry + RETRY_W'(1);
                        state_nxt = GAP;
                        timer_nxt = '0;
                        ok_nxt    = 1'b0;
                    end else begin
                        state_nxt = FAIL;
                        busy_nxt  = 1'b0;
                        error_nxt = 1'b1;
                    end
                end
            end
            GAP: begin
                timer_nxt = timer + TIMER_W'(1);
                if (timer == TIMER_W'(GAP_CYC - 1)) begin
                    timer_nxt = '0;
                    if (ok && (cmd_idx == CMD_W'(NUM_CMDS - 1))) begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        if (ok) begin
                            cmd_nxt   = cmd_idx + CMD_W'(1);
                            retry_nxt = '0;
                        end
                        chr_nxt      = '0;
                        state_nxt    = SEND;
                        tx_valid_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; tx_data only reloads while sending.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd_idx    <= '0;
            chr        <= '0;
            retry      <= '0;
            timer      <= '0;
            m1         <= 1'b0;
            ok         <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            last_q     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cmd_idx    <= cmd_nxt;
            chr        <= chr_nxt;
            retry      <= retry_nxt;
            timer      <= timer_nxt;
            m1         <= m1_nxt;
            ok         <= ok_nxt;
            tx_valid_q <= tx_valid_nxt;
            tx_data_q  <= (state_nxt == SEND) ? rom_data : tx_data_q;
            last_q     <= rom_last;
            busy       <= busy_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
        end
    end
endmodule

// File: tb/tb_hm10_at_sequencer.sv
// Bench for hm10_at_sequencer: byte scoreboard, table of reply patterns, corner sequences.
module tb_hm10_at_sequencer;
    localparam int TO = 1000;
    localparam int GP = 50;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       reset, start;
    logic       busy, done, error;
    logic [1:0] cmd_idx;

    hm10_at_sequencer_if bus();

    hm10_at_sequencer #(.TIMEOUT_CYC(TO), .GAP_CYC(GP), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .done(done), .error(error), .cmd_idx(cmd_idx)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [95:0] str;
        int          len;
        logic [1:0]  exp_idx;
    } mvec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_acc = 0;
    int         bytes_sent = 0;
    logic [7:0] exp_q[$];
    mvec_t      mv[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance n cycles from a negedge; accepted bytes are scored against the queue.
    task automatic tick(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            #1;
            if (!reset && bus.tx_valid && bus.tx_ready) begin
                bytes_sent++;
                last_acc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_byte: got unexpected %0h expected none (cycle %0d)", bus.tx_data, cyc);
                end else begin
                    b = exp_q.pop_front();
                    check("tx_byte", {24'd0, bus.tx_data}, {24'd0, b});
                end
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic push_cmd(input int k);
        string s;
        case (k)
            0:       s = "AT";
            1:       s = "AT+NAMEFPGA";
            default: s = "AT+ROLE0";
        endcase
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        exp_q.delete();
        tick(1);
        reset = 1'b0;
    endtask

    task automatic wait_sent(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) tick(1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic inject(input logic [95:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = s[8*(n-1-i) +: 8];
            tick(1);
        end
        bus.rx_valid = 1'b0;
    endtask

    // Edge index after which tx_valid was first seen high.
    task automatic wait_valid(input int bound, output int e);
        logic seen = 1'b0;
        e = -1;
        for (int i = 0; i < bound; i++) begin
            if (bus.tx_valid) begin
                seen = 1'b1;
                e = cyc - 1;
                break;
            end
            tick(1);
        end
        check("wait_tx_valid", {31'd0, seen}, 1);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  e, a;
        logic found;

        mv[0] = '{"OK",          2,  2'd1};
        mv[1] = '{"XOOK",        4,  2'd1};
        mv[2] = '{"OXK",         3,  2'd0};
        mv[3] = '{"OK+Set:FPGA", 11, 2'd1};
        mv[4] = '{"KO",          2,  2'd0};
        mv[5] = '{"OOK",         3,  2'd1};

        reset = 1'b1; start = 1'b0;
        bus.tx_ready = 1'b1; bus.rx_valid = 1'b0; bus.rx_data = '0;
        @(negedge clk);
        tick(2);
        check("rst_tx_valid", {31'd0, bus.tx_valid}, 0);
        check("rst_tx_data",  {24'd0, bus.tx_data}, 0);
        check("rst_busy",     {31'd0, busy}, 0);
        check("rst_done",     {31'd0, done}, 0);
        check("rst_error",    {31'd0, error}, 0);
        check("rst_cmd_idx",  {30'd0, cmd_idx}, 0);
        reset = 1'b0;
        tick(2);

        // Happy path with tx_ready tied high.
        bytes_sent = 0;
        push_cmd(0);
        pulse_start();
        check("start_busy", {31'd0, busy}, 1);
        check("start_valid", {31'd0, bus.tx_valid}, 1);
        wait_sent(50);
        inject("OK", 2);
        push_cmd(1);
        wait_sent(200);
        inject("OK+Set:FPGA", 11);
        push_cmd(2);
        wait_sent(200);
        inject("OK", 2);
        tick(GP + 5);
        check("happy_done",  {31'd0, done}, 1);
        check("happy_busy",  {31'd0, busy}, 0);
        check("happy_error", {31'd0, error}, 0);
        check("happy_bytes", bytes_sent, 21);

        // Backpressure on 'N', then start while busy.
        do_reset();
        push_cmd(0);
        pulse_start();
        wait_sent(50);
        inject("OK", 2);
        push_cmd(1);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.tx_valid && bus.tx_data == 8'h4E) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        check("bp_found_N", {31'd0, found}, 1);
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("bp_valid", {31'd0, bus.tx_valid}, 1);
            check("bp_data",  {24'd0, bus.tx_data}, 32'h4E);
        end
        bus.tx_ready = 1'b1;
        wait_sent(50);
        pulse_start();
        check("busy_start_valid", {31'd0, bus.tx_valid}, 0);
        check("busy_start_busy",  {31'd0, busy}, 1);
        check("busy_start_idx",   {30'd0, cmd_idx}, 1);

        // Timeout and retry until failure.
        do_reset();
        bytes_sent = 0;
        push_cmd(0);
        pulse_start();
        wait_sent(50);
        for (int k = 0; k < MR; k++) begin
            a = last_acc;
            push_cmd(0);
            wait_valid(1200, e);
            check("resend_delay", e - a, TO + GP);
            wait_sent(50);
        end
        a = last_acc;
        for (int i = 0; i < 1200 && !error; i++) tick(1);
        check("fail_error",   {31'd0, error}, 1);
        check("fail_time",    (cyc - 1) - a, TO);
        check("fail_busy",    {31'd0, busy}, 0);
        check("fail_idx",     {30'd0, cmd_idx}, 0);
        check("fail_valid",   {31'd0, bus.tx_valid}, 0);
        tick(100);
        check("fail_bytes",   bytes_sent, 6);
        push_cmd(0);
        pulse_start();
        check("restart_error", {31'd0, error}, 0);
        check("restart_busy",  {31'd0, busy}, 1);
        check("restart_idx",   {30'd0, cmd_idx}, 0);
        wait_sent(50);

        // Reply pattern table.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            push_cmd(0);
            pulse_start();
            wait_sent(50);
            inject(mv[t].str, mv[t].len);
            push_cmd(int'(mv[t].exp_idx));
            wait_valid(1200, e);
            check($sformatf("match_idx_%0d", t), {30'd0, cmd_idx}, {30'd0, mv[t].exp_idx});
            wait_sent(200);
        end

        // "OK" arriving during the gap is discarded.
        do_reset();
        push_cmd(0);
        pulse_start();
        wait_sent(50);
        inject("OK", 2);
        tick(10);
        inject("OK", 2);
        push_cmd(1);
        wait_sent(200);
        a = last_acc;
        push_cmd(1);
        wait_valid(1200, e);
        check("gap_discard_delay", e - a, TO + GP);
        check("gap_discard_idx", {30'd0, cmd_idx}, 1);
        wait_sent(200);

        // 'K' on the final timeout cycle counts as a match.
        do_reset();
        push_cmd(0);
        pulse_start();
        wait_sent(50);
        a = last_acc;
        for (int i = 0; i < 2000 && cyc < a + TO - 1; i++) tick(1);
        inject("OK", 2);
        push_cmd(1);
        wait_valid(200, e);
        check("tie_delay", e - (a + TO), GP);
        check("tie_idx", {30'd0, cmd_idx}, 1);
        wait_sent(50);

        // Reset in the middle of SEND.
        do_reset();
        bus.tx_ready = 1'b0;
        pulse_start();
        tick(3);
        check("midrst_pre_valid", {31'd0, bus.tx_valid}, 1);
        reset = 1'b1;
        tick(1);
        check("midrst_valid", {31'd0, bus.tx_valid}, 0);
        check("midrst_busy",  {31'd0, busy}, 0);
        check("midrst_idx",   {30'd0, cmd_idx}, 0);
        reset = 1'b0;
        bus.tx_ready = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hm10_at_sequencer.md
Name: hm10_at_sequencer

Overview:
Controller that configures the HM-10 Bluetooth module at power-up or on request. It sends a fixed list of AT commands, one byte at a time, over the UART transmitter's byte handshake. It then watches the byte stream from the UART receiver for an "OK" reply. Sits between the UART TX/RX byte interfaces and top-level status LEDs; retries on timeout and reports done or error.

Parameters:
TIMEOUT_CYC, 25000000, cycles to wait for "OK" after the last command byte is accepted (500 ms at 50 MHz).
GAP_CYC, 1000000, quiet cycles after each reply or timeout before the next transmission (20 ms). Bytes arriving during the gap are discarded.
MAX_RETRY, 3, extra attempts per command after the first one times out.

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins the sequence from command 0
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data is valid
tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe per received byte
busy  out  1  sequence in progress
done  out  1  sticky: all commands acknowledged
error  out  1  sticky: a command exhausted its retries
cmd_idx  out  2  index of the current command

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset:
  - state=IDLE.
  - tx_valid, busy, done, error = 0.
  - tx_data = 0, cmd_idx = 0.
  - All counters cleared.
  - Reset asserted mid-operation aborts at the next edge; there is no partial flush.
- Command list, fixed, ASCII, no CR/LF:
  - 0: "AT" (2 bytes)
  - 1: "AT+NAMEFPGA" (11 bytes)
  - 2: "AT+ROLE0" (8 bytes)
- IDLE / DONE / FAIL:
  - start → SEND.
  - On entry: cmd_idx=0, char=0, retry=0, done=0, error=0, busy=1.
- SEND:
  - tx_valid=1; tx_data = rom[cmd_idx][char].
  - tx_data and tx_valid hold stable until tx_ready.
  - On accept: if last char → WAIT_RSP (timer=0, match=0); else char++.
  - rx bytes are ignored in SEND.
- WAIT_RSP matcher, 2-state, updated only on rx_valid:
  - m0: 'O'(8'h4F) → m1.
  - m1: 'K'(8'h4B) → matched; 'O' → stay in m1; any other byte → m0.
  - Any prefix or suffix bytes ("XOK", "OK+Set:FPGA") are accepted.
  - Timer increments every cycle.
  - matched → GAP with ok=1.
  - Timer reaches TIMEOUT_CYC-1 without a match:
    - retry<MAX_RETRY → retry++, GAP with ok=0.
    - otherwise → FAIL.
  - Match and timeout in the same cycle: match wins.
- GAP:
  - Counts GAP_CYC cycles, then:
    - ok && cmd_idx==2 → DONE.
    - ok → cmd_idx++, char=0, retry=0, SEND.
    - !ok → char=0, SEND (resend same command).
- DONE: busy=0, done=1.
- FAIL: busy=0, error=1, cmd_idx frozen at the failing command.
- start while busy is ignored.
- Attempts per command = 1+MAX_RETRY.
- Counter widths: $clog2 of the respective parameter; the timer is sized for max(TIMEOUT_CYC, GAP_CYC).
- All outputs are registered.

Decomposition:
- Package hm10_cfg_pkg:
  - State encoding: IDLE, SEND, WAIT_RSP, GAP, DONE, FAIL.
  - ASCII constants ASCII_O, ASCII_K.
  - NUM_CMDS=3.
  - Per-command lengths.
- Sub-module hm10_cmd_rom: combinational; (cmd_idx, char) → byte, last flag. Keeps string contents out of the FSM.

Test Plan (TIMEOUT_CYC=1000, GAP_CYC=50, MAX_RETRY=2):
- Happy path, tx_ready tied 1:
  - start → bytes 41 54; inject "OK" → after 50 cycles, "AT+NAMEFPGA"; inject "OK+Set:FPGA" → "AT+ROLE0"; inject "OK".
  - Required: done=1, busy=0, error=0; exactly 21 bytes sent.
- Backpressure: tx_ready low 5 cycles during byte 'N' → tx_valid=1 and tx_data=8'h4E held all 5 cycles; no byte skipped or duplicated.
- Timeout and retry: no reply to cmd 0 → "AT" resent 1050 cycles after last-byte accept, 3 times total; then error=1, busy=0, cmd_idx=0.
- Matcher: "XOOK" accepted; "OXK" not accepted, times out; "OK" arriving during GAP discarded.
- Same-cycle tie: 'K' strobe exactly on timer==TIMEOUT_CYC-1 → treated as success, cmd_idx advances, retry not incremented.
- Reset and start rules:
  - reset mid-SEND → next cycle tx_valid=0, busy=0, cmd_idx=0.
  - start while busy → no restart.
  - start after FAIL → error cleared, sequence restarts at cmd 0.
